// File: rtl/systolic_output_collector_pkg.sv
// systolic_output_collector_pkg: shared PE-array constants and the completing-PE selector
package systolic_output_collector_pkg;
  localparam int NUM_PE = 8;
  localparam int WARMUP_STROBES = 7;
  function automatic logic [2:0] completing_pe(input logic [2:0] w);
    return w + 3'd1;
  endfunction
endpackage

// File: rtl/systolic_output_collector_fifo.sv
// collector_fifo: synchronous FIFO with registered storage, accepts push on a full+pop edge
module collector_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] used;
  logic do_push, do_pop;
  assign empty = used == '0;
  assign full = used == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      used <= used + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: mirrors the PE sample schedule and streams completed words out
module systolic_output_collector
  import systolic_output_collector_pkg::*;
#(
  parameter int WORDLENGTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk30x,
  input  logic                       reset,
  input  logic [8*WORDLENGTH-1:0]    pe_words,
  input  logic [31:0]                timing,
  output logic [WORDLENGTH-1:0]      out_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [15:0]                sample_count
);
  logic [31:0] count;
  logic [2:0] word_index, warm;
  logic strobe, push, pop, accept, full, empty;
  logic [WORDLENGTH-1:0] sel;
  assign strobe = !reset && (count == timing);
  assign push = strobe && (warm == 3'(WARMUP_STROBES));
  assign sel = pe_words[int'(completing_pe(word_index))*WORDLENGTH +: WORDLENGTH];
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign accept = push && (!full || pop);
  always_ff @(posedge clk30x) begin
    if (reset) begin
      count <= '1;
      word_index <= '0;
      warm <= '0;
      overflow <= 1'b0;
      sample_count <= '0;
    end else begin
      count <= strobe ? '0 : count + 32'd1;
      if (strobe) word_index <= word_index + 3'd1;
      if (strobe && warm != 3'(WARMUP_STROBES)) warm <= warm + 3'd1;
      if (accept) sample_count <= sample_count + 16'd1;
      if (push && !accept) overflow <= 1'b1;
    end
  end
  collector_fifo #(.WIDTH(WORDLENGTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk30x),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(sel),
    .dout(out_word),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Downstream stage of the 8-PE systolic interpolation array. Each cycle it watches the eight PE `outputword` buses and, on each sample strobe, captures the one PE whose 8-word accumulation has just completed. It discards warm-up windows, buffers results in a small FIFO, and presents them on a ready/valid stream to the output/DAC side. It mirrors the PE sample schedule exactly, so the captured word always equals the PE's `previousOutputword` latched on the same edge.

## Interface
Parameters:
- `WORDLENGTH`, 16: sample width; must match the PEs.
- `FIFO_DEPTH`, 4: output buffer entries, power of two.

Ports:
- `clk30x` in 1: the single clock, shared with the PEs.
- `reset` in 1: synchronous, active-high; same reset net as the PEs.
- `pe_words` in 8*WORDLENGTH: PE k `outputword` on bits [k*WORDLENGTH +: WORDLENGTH], k=0..7.
- `timing` in 32: sample period minus one, same value driven to the PEs.
- `out_word` out WORDLENGTH: head-of-FIFO interpolated sample.
- `out_valid` out 1: `out_word` is valid.
- `out_ready` in 1: consumer accepts the word when `out_valid` is high on this edge.
- `overflow` out 1: sticky; a completed sample was dropped because the FIFO was full.
- `sample_count` out 16: number of samples pushed since reset; wraps at 16'hFFFF→0.

## Operation
- Schedule mirror:
  - On reset: `count`=32'hFFFF_FFFF, `wordIndex`=0.
  - Otherwise, if `count`!=`timing` then `count`++.
  - Else it is a strobe cycle: `count`←0 and `wordIndex`←`wordIndex`+1 (3-bit wrap).
  - Equivalently, `strobe` = !reset && (`count`==`timing`).
- Selection: on a strobe with `wordIndex`=w, select PE k = (w+1) mod 8. PE k has startIndex k, so its window completes at w=(k+7) mod 8.
- Warm-up:
  - A 3-bit warm-up counter starts at 0 on reset and increments on each strobe, saturating at 7.
  - Strobes seen while it is <7 are discarded; these are the first 7 strobes, w=0..6.
  - The first pushed sample is PE0 at w=7. After that every strobe pushes.
- Push: on a non-discarded strobe the selected word is written to the FIFO and `sample_count`++.
- FIFO full at a push:
  - If `out_ready`&&`out_valid` on the same edge, pop and push both occur and nothing is lost.
  - Otherwise the sample is dropped, `overflow`←1, and `sample_count` does not increment.
- Pop: occurs when `out_valid`&&`out_ready`. There is no combinational bypass from `pe_words` to `out_word`.
- Data: the selected word is passed bit-exact, with no rounding or saturation.
- `timing` changes take effect on the next comparison with no resynchronisation. If the new `timing` is less than `count`, `count` runs through the 32-bit wrap, exactly as the PEs do.
- Reset mid-operation:
  - FIFO is flushed.
  - `out_valid`=0, `out_word`=0, `overflow`=0, `sample_count`=0.
  - Warm-up restarts.
  - No partial sample is emitted.

## Timing
- Reset values: every output is 0.
- Strobe spacing is `timing`+1 clocks. After reset release the first strobe occurs on the (`timing`+2)th rising edge, when `count` reaches `timing`.
- Latency: the word is captured on the strobe edge and `out_valid`=1 from the following cycle if the FIFO was empty. This is one cycle from the PE latch edge.
- `out_word`/`out_valid` are registered and held stable while `out_valid`&&!`out_ready`.
- Throughput: at most one push per strobe and at most one pop per cycle. With `timing`=0 (strobe every cycle), `out_ready` held high sustains full rate with no overflow.

## Structure
- Shared include (alongside the coefficient-row includes):
  - `NUM_PE`=8.
  - `WARMUP_STROBES`=7.
  - Function `completing_pe(w)` = (w+1)%8. The PE array testbench uses the same function.
- One sub-module, `collector_fifo` (WORDLENGTH × FIFO_DEPTH):
  - Synchronous, registered output.
  - Ports: push, pop, din, dout, full, empty, and simultaneous push/pop.
- Top level contains the schedule mirror, warm-up counter, selection mux, overflow/counter logic and the FIFO instance.

## Test plan
- **Warm-up:** `timing`=3, pe k drives 16'h0100+k, `out_ready`=1. Strobes 1–7 push nothing. Strobe 8 (w=7) yields `out_word`=16'h0100 one cycle later; subsequent words are 16'h0101, 16'h0102, … every 4 clocks. `sample_count` increments by 1 per push.
- **Selection vs PE:** instantiate 8 real `systolic_PE*` instances with the same `timing`. On every push after warm-up, the pushed word equals the completing PE's `previousOutputword` captured on the same edge.
- **Back-pressure/overflow:** `timing`=0, `out_ready`=0. After warm-up, 4 pushes fill the FIFO and the 5th strobe sets `overflow`=1 with `sample_count`=4. Raising `out_ready` drains the 4 words in order; `overflow` stays 1.
- **Full with simultaneous pop:** FIFO full, `out_ready`=1 on the strobe edge. Pop and push both occur, no overflow, and the count increments.
- **Reset mid-run:** assert `reset` for 1 cycle with 3 words buffered. Next cycle all outputs are 0, and the first post-reset push occurs only after 7 discarded strobes.
- **`timing` change:** switch `timing` from 9 to 2 when `count`=5. `count` wraps through 32 bits before the next strobe, matching the PE array exactly (bit-for-bit compare of strobe cycles).
